// File: rtl/vector_multiply_sequencer.sv
// Issue/writeback sequencer for vector_multiply_unit: walks vs2/vs1/vd register groups one 64-bit chunk per cycle.
// Optional build macro VECTOR_MULTIPLY_SEQUENCER_TAIL_UNDISTURBED_EN masks tail bytes of the final chunk write.

package dragonfang_pkg;
  typedef struct packed {
    logic vmul;
    logic vmulh;
    logic vmulhu;
    logic vmulhsu;
  } execution_vector_t;
endpackage

module vector_multiply_sequencer
  import dragonfang_pkg::*;
#(
  parameter int VLEN             = 512,
  parameter int CHUNKS_PER_REG   = VLEN / 64,
  parameter int CHUNK_ADDR_WIDTH = 5 + $clog2(CHUNKS_PER_REG),
  parameter int VL_WIDTH         = $clog2(VLEN) + 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        request_valid,
  output logic                        request_ready,
  input  execution_vector_t           request_execution_vector,
  input  logic [1:0]                  request_sew,
  input  logic [VL_WIDTH-1:0]         request_vl,
  input  logic [4:0]                  request_vs2,
  input  logic [4:0]                  request_vs1,
  input  logic [4:0]                  request_vd,
  output logic [CHUNK_ADDR_WIDTH-1:0] read_address_vs2,
  output logic [CHUNK_ADDR_WIDTH-1:0] read_address_vs1,
  input  logic [63:0]                 read_data_vs2,
  input  logic [63:0]                 read_data_vs1,
  output execution_vector_t           multiply_execution_vector,
  output logic [63:0]                 multiply_vs2,
  output logic [63:0]                 multiply_vs1,
  input  logic [63:0]                 multiply_vd,
  output logic                        write_enable,
  output logic [CHUNK_ADDR_WIDTH-1:0] write_address,
  output logic [63:0]                 write_data,
  output logic [7:0]                  write_byte_enable,
  output logic                        busy,
  output logic                        done
);

  localparam int DATA_W    = 64;
  localparam int BYTES_W   = $clog2(VLEN) + 1;      // active bytes never exceed one LMUL=8 group of VLEN bytes
  localparam int CNT_W     = $clog2(VLEN / 8) + 1;  // up to 8 registers worth of chunks
  localparam int IDX_SHIFT = $clog2(CHUNKS_PER_REG);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                state;
  logic [CNT_W-1:0]      issue_idx;
  logic [CNT_W-1:0]      chunks_q;
  logic [4:0]            vs2_q;
  logic [4:0]            vs1_q;
  logic [4:0]            vd_q;
`ifdef VECTOR_MULTIPLY_SEQUENCER_TAIL_UNDISTURBED_EN
  logic [2:0]            tail_q;
`endif

  logic                  vld_p0, vld_p1, vld_p2;
  logic [CNT_W-1:0]      idx_p0, idx_p1, idx_p2;
  logic                  last_p0, last_p1, last_p2;

  logic [VL_WIDTH-1:0]   vlmax;
  logic [VL_WIDTH-1:0]   vl_eff;
  logic [BYTES_W-1:0]    req_bytes;
  logic [CNT_W-1:0]      req_chunks;
  logic                  accept;

  function automatic logic [CHUNK_ADDR_WIDTH-1:0] chunk_addr(input logic [4:0] base,
                                                             input logic [CNT_W-1:0] idx);
    logic [CHUNK_ADDR_WIDTH-1:0] group;
    group = CHUNK_ADDR_WIDTH'(base) << IDX_SHIFT;
    return group + CHUNK_ADDR_WIDTH'(idx);
  endfunction

`ifdef VECTOR_MULTIPLY_SEQUENCER_TAIL_UNDISTURBED_EN
  // A zero remainder means the final chunk is fully populated.
  function automatic logic [7:0] tail_mask(input logic [2:0] active);
    if (active == 3'd0) return 8'hFF;
    return 8'hFF >> (4'd8 - {1'b0, active});
  endfunction
`endif

  // VLMAX at LMUL=8 is VLEN >> sew_code elements; total bytes scale back up by the same shift.
  always_comb begin
    vlmax      = VL_WIDTH'(VLEN) >> request_sew;
    vl_eff     = (request_vl > vlmax) ? vlmax : request_vl;
    req_bytes  = BYTES_W'(vl_eff) << request_sew;
    req_chunks = CNT_W'((req_bytes + BYTES_W'(7)) >> 3);
    accept     = (state == IDLE) && request_valid;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state                     <= IDLE;
      request_ready             <= 1'b1;
      busy                      <= 1'b0;
      done                      <= 1'b0;
      vld_p0                    <= 1'b0;
      vld_p1                    <= 1'b0;
      vld_p2                    <= 1'b0;
      read_address_vs2          <= '0;
      read_address_vs1          <= '0;
      multiply_execution_vector <= '0;
      multiply_vs2              <= '0;
      multiply_vs1              <= '0;
      write_enable              <= 1'b0;
      write_address             <= '0;
      write_data                <= '0;
      write_byte_enable         <= '0;
    end else begin
      // p0 -> p1: register-file read in flight
      vld_p1 <= vld_p0;

      // p1 -> p2: read data registered as multiply operands
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        multiply_vs2 <= read_data_vs2;
        multiply_vs1 <= read_data_vs1;
      end

      // p2 -> write port: combinational product captured
      write_enable <= vld_p2;
      if (vld_p2) begin
        write_address <= chunk_addr(vd_q, idx_p2);
        write_data    <= multiply_vd[DATA_W-1:0];
      end
`ifdef VECTOR_MULTIPLY_SEQUENCER_TAIL_UNDISTURBED_EN
      write_byte_enable <= !vld_p2 ? 8'h00 : (last_p2 ? tail_mask(tail_q) : 8'hFF);
`else
      write_byte_enable <= {8{vld_p2}};
`endif

      vld_p0 <= 1'b0;
      done   <= 1'b0;

      case (state)
        IDLE: begin
          if (request_valid) begin
            multiply_execution_vector <= request_execution_vector;
            request_ready             <= 1'b0;
            busy                      <= 1'b1;
            if (req_chunks != '0) begin
              read_address_vs2 <= chunk_addr(request_vs2, '0);
              read_address_vs1 <= chunk_addr(request_vs1, '0);
              vld_p0           <= 1'b1;
              idx_p0           <= '0;
              last_p0          <= (req_chunks == CNT_W'(1));
              issue_idx        <= CNT_W'(1);
              state            <= ISSUE;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        ISSUE: begin
          if (issue_idx < chunks_q) begin
            read_address_vs2 <= chunk_addr(vs2_q, issue_idx);
            read_address_vs1 <= chunk_addr(vs1_q, issue_idx);
            vld_p0           <= 1'b1;
            idx_p0           <= issue_idx;
            last_p0          <= (issue_idx == chunks_q - CNT_W'(1));
            issue_idx        <= issue_idx + CNT_W'(1);
          end else begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          // done is raised on the same edge that launches the final write.
          if (vld_p2 && last_p2) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          request_ready <= 1'b1;
          busy          <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Request fields and per-chunk indices travel without reset; the valid bits above qualify them.
  always_ff @(posedge clock) begin
    if (accept) begin
      chunks_q <= req_chunks;
      vs2_q    <= request_vs2;
      vs1_q    <= request_vs1;
      vd_q     <= request_vd;
`ifdef VECTOR_MULTIPLY_SEQUENCER_TAIL_UNDISTURBED_EN
      tail_q   <= req_bytes[2:0];
`endif
    end
    idx_p1  <= idx_p0;
    last_p1 <= last_p0;
    idx_p2  <= idx_p1;
    last_p2 <= last_p1;
  end

endmodule
